// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: grant encodings,
// default bus widths and the watchdog counter width.
package mem_arb_pkg;

   localparam int ADDR_W_DEF  = 28;
   localparam int BLOCK_W_DEF = 128;
   localparam int WDOG_W      = 8;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_GNT_I = 2'b01;
   localparam logic [1:0] ST_GNT_D = 2'b10;

   typedef logic [WDOG_W-1:0] wdog_cnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Block-transfer handshake (req/wr/addr/data out, rdy/q back) shared by
// the cache controllers and the memory port.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int BLOCK_W = BLOCK_W_DEF
) ();

   logic               req;
   logic               wr;
   logic [ADDR_W-1:0]  a;
   logic [BLOCK_W-1:0] d;
   logic               rdy;
   logic [BLOCK_W-1:0] q;

   modport master (output req, output wr, output a, output d, input rdy, input q);
   modport slave  (input req, input wr, input a, input d, output rdy, output q);

endinterface

// File: rtl/mem_arb_watchdog.sv
// Per-transaction watchdog: saturating up-counter that flags the last
// permitted cycle of a grant still waiting for memory.
module mem_arb_watchdog
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam wdog_cnt_t LP_LAST = WDOG_W'(LIMIT - 1);

   wdog_cnt_t r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Counter holds (cycles already waited); expiry fires in cycle LIMIT of the grant.
   assign o_expire = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I- and D-cache
// controllers, holding each grant until Rdy from memory or watchdog expiry.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | no grant; memory outputs zero; choose next requester
// ST_GNT_I | I-cache owns the memory port until Rdy or timeout
// ST_GNT_D | D-cache owns the memory port until Rdy or timeout
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int BLOCK_W = BLOCK_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   mem_arbiter_if.slave   if_icache,
   mem_arbiter_if.slave   if_dcache,
   mem_arbiter_if.master  if_mem,
   output logic           Err
);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic               r_last;
   logic               w_last_nxt;
   logic               r_err;
   logic               w_set_err;
   logic               w_granted;
   logic               w_expire;
   logic               w_req_mem;
   logic               w_wr_mem;
   logic [ADDR_W-1:0]  w_a_mem;
   logic [BLOCK_W-1:0] w_d_mem;

   assign w_granted = (r_state == ST_GNT_I) || (r_state == ST_GNT_D);

   mem_arb_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (!w_granted),
      .i_en     (w_granted && !if_mem.rdy),
      .o_expire (w_expire)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_set_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // r_last = 1 means D was served last, so a tie goes to I.
            if (if_icache.req && if_dcache.req) begin
               w_state_nxt = r_last ? ST_GNT_I : ST_GNT_D;
            end else if (if_icache.req) begin
               w_state_nxt = ST_GNT_I;
            end else if (if_dcache.req) begin
               w_state_nxt = ST_GNT_D;
            end
         end
         ST_GNT_I, ST_GNT_D: begin
            if (if_mem.rdy || w_expire) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = (r_state == ST_GNT_D);
               w_set_err   = !if_mem.rdy;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         if (w_set_err) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_req_mem = 1'b0;
      w_wr_mem  = 1'b0;
      w_a_mem   = '0;
      w_d_mem   = '0;
      case (r_state)
         ST_GNT_I: begin
            w_req_mem = 1'b1;
            w_wr_mem  = if_icache.wr;
            w_a_mem   = if_icache.a;
            w_d_mem   = if_icache.d;
         end
         ST_GNT_D: begin
            w_req_mem = 1'b1;
            w_wr_mem  = if_dcache.wr;
            w_a_mem   = if_dcache.a;
            w_d_mem   = if_dcache.d;
         end
         default: begin
            w_req_mem = 1'b0;
         end
      endcase
   end

   assign if_mem.req = w_req_mem;
   assign if_mem.wr  = w_wr_mem;
   assign if_mem.a   = w_a_mem;
   assign if_mem.d   = w_d_mem;

   // A grant being torn down by reset must not report completion.
   assign if_icache.rdy = (r_state == ST_GNT_I) && if_mem.rdy && !rst;
   assign if_dcache.rdy = (r_state == ST_GNT_D) && if_mem.rdy && !rst;

   assign if_icache.q = if_mem.q;
   assign if_dcache.q = if_mem.q;

   assign Err = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table for the handshake corner
// cases, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

   localparam int AW = 28;
   localparam int BW = 128;
   localparam int TO = 4;
   localparam int OW = 5 + AW + 3 * BW;

   logic clk = 1'b0;
   logic rst;
   logic err;

   mem_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) if_i ();
   mem_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) if_d ();
   mem_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) if_m ();

   mem_arbiter #(
      .ADDR_W  (AW),
      .BLOCK_W (BW),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_icache (if_i),
      .if_dcache (if_d),
      .if_mem    (if_m),
      .Err       (err)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   // stim = {rst, req_i, wr_i, req_d, wr_d, rdy_mem}
   // exp  = {req_mem, wr_mem, rdy_i, rdy_d, err}; sel: 0 none, 1 I, 2 D
   typedef struct {
      logic [5:0] stim;
      logic [4:0] exp;
      int         sel;
   } vec_t;

   vec_t vecs[$];

   // Transaction-level reference: who owns the port, how long it has waited.
   int m_own  = -1;
   bit m_last = 1'b1;
   int m_age  = 0;
   bit m_err  = 1'b0;

   task automatic add(input logic [5:0] s, input logic [4:0] e, input int sel);
      vec_t v;
      v.stim = s;
      v.exp  = e;
      v.sel  = sel;
      vecs.push_back(v);
   endtask

   task automatic apply(input logic [5:0] s);
      rst        = s[5];
      if_i.req   = s[4];
      if_i.wr    = s[3];
      if_d.req   = s[2];
      if_d.wr    = s[1];
      if_m.rdy   = s[0];
   endtask

   function automatic logic [OW-1:0] observed();
      return {if_m.req, if_m.wr, if_i.rdy, if_d.rdy, err, if_m.a, if_m.d, if_i.q, if_d.q};
   endfunction

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] model_out();
      logic [AW-1:0] ea;
      logic [BW-1:0] ed;
      logic          ew;
      ea = '0;
      ed = '0;
      ew = 1'b0;
      if (m_own == 0) begin
         ea = if_i.a; ed = if_i.d; ew = if_i.wr;
      end else if (m_own == 1) begin
         ea = if_d.a; ed = if_d.d; ew = if_d.wr;
      end
      return {(m_own >= 0), ew,
              (m_own == 0) && if_m.rdy && !rst,
              (m_own == 1) && if_m.rdy && !rst,
              m_err, ea, ed, if_m.q, if_m.q};
   endfunction

   task automatic model_step();
      if (rst) begin
         m_own = -1; m_last = 1'b1; m_age = 0; m_err = 1'b0;
      end else if (m_own < 0) begin
         if (if_i.req && if_d.req) m_own = m_last ? 0 : 1;
         else if (if_i.req)        m_own = 0;
         else if (if_d.req)        m_own = 1;
         m_age = 1;
      end else if (if_m.rdy) begin
         m_last = (m_own == 1);
         m_own  = -1;
      end else if (m_age >= TO) begin
         m_err  = 1'b1;
         m_last = (m_own == 1);
         m_own  = -1;
      end else begin
         m_age++;
      end
   endtask

   initial begin
      logic [AW-1:0] ea;
      logic [BW-1:0] ed;

      apply(6'b100000);
      if_i.a = 28'h0000123;
      if_d.a = 28'h0000456;
      if_i.d = 128'h11111111_22222222_33333333_44444444;
      if_d.d = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      if_m.q = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

      // reset
      add(6'b100000, 5'b00000, 0);
      // I-cache alone, Rdy_Mem in grant cycle 4
      add(6'b010000, 5'b00000, 0);
      add(6'b010000, 5'b10000, 1);
      add(6'b010000, 5'b10000, 1);
      add(6'b010000, 5'b10000, 1);
      add(6'b000001, 5'b10100, 1);
      add(6'b000000, 5'b00000, 0);
      // tie after reset: I, then D, then I again
      add(6'b100000, 5'b00000, 0);
      add(6'b010100, 5'b00000, 0);
      add(6'b010101, 5'b10100, 1);
      add(6'b000100, 5'b00000, 0);
      add(6'b000101, 5'b10010, 2);
      add(6'b010100, 5'b00000, 0);
      add(6'b010100, 5'b10000, 1);
      add(6'b000001, 5'b10100, 1);
      add(6'b000000, 5'b00000, 0);
      // D-cache write-back then miss fill
      add(6'b000110, 5'b00000, 0);
      add(6'b000110, 5'b11000, 2);
      add(6'b000111, 5'b11010, 2);
      add(6'b000100, 5'b00000, 0);
      add(6'b000101, 5'b10010, 2);
      add(6'b000000, 5'b00000, 0);
      // Rdy_Mem in IDLE ignored; reset with Rdy_Mem during GNT_I
      add(6'b000001, 5'b00000, 0);
      add(6'b010000, 5'b00000, 0);
      add(6'b010000, 5'b10000, 1);
      add(6'b110001, 5'b10000, 1);
      add(6'b000000, 5'b00000, 0);
      // watchdog expiry on D, sticky Err until reset
      add(6'b000100, 5'b00000, 0);
      add(6'b000100, 5'b10000, 2);
      add(6'b000100, 5'b10000, 2);
      add(6'b000100, 5'b10000, 2);
      add(6'b000100, 5'b10000, 2);
      add(6'b000100, 5'b00001, 0);
      add(6'b000000, 5'b10001, 2);
      add(6'b000001, 5'b10011, 2);
      add(6'b000000, 5'b00001, 0);
      add(6'b100000, 5'b00001, 0);
      add(6'b000000, 5'b00000, 0);

      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[k]) begin
         apply(vecs[k].stim);
         ea = (vecs[k].sel == 1) ? if_i.a : ((vecs[k].sel == 2) ? if_d.a : '0);
         ed = (vecs[k].sel == 1) ? if_i.d : ((vecs[k].sel == 2) ? if_d.d : '0);
         @(negedge clk);
         check($sformatf("vec%0d", k), observed(), {vecs[k].exp, ea, ed, if_m.q, if_m.q});
         @(posedge clk);
         #1;
      end

      for (int c = 0; c < 3000; c++) begin
         rst      = (c == 0) || ($urandom_range(99) == 0);
         if_i.req = ($urandom_range(1) == 1);
         if_d.req = ($urandom_range(1) == 1);
         if_i.wr  = ($urandom_range(1) == 1);
         if_d.wr  = ($urandom_range(1) == 1);
         if_m.rdy = ($urandom_range(99) < 30);
         if_i.a   = AW'($urandom);
         if_d.a   = AW'($urandom);
         if_i.d   = {$urandom, $urandom, $urandom, $urandom};
         if_d.d   = {$urandom, $urandom, $urandom, $urandom};
         if_m.q   = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check($sformatf("rand%0d", c), observed(), model_out());
         @(posedge clk);
         model_step();
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single lower-level memory port between the instruction-cache and data-cache controllers. Each controller drives the same Req/Wr/Rdy handshake it would present to memory. The arbiter grants one requester at a time and holds the grant for a whole transaction. It uses round-robin fairness and a per-transaction watchdog. It sits between the two cache controllers and the memory model/bus interface.

## Interface
- ADDR_W, 28, block address width (A[31:4]; 16-byte, 4-word blocks)
- BLOCK_W, 128, block data width (4 x 32-bit words)
- TIMEOUT, 255, max cycles a grant may wait for Rdy_Mem; must be ≥1 and fit in 8 bits
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- Req_I, Wr_I  in  1 each  I-cache request / write (write-back) qualifier
- A_I  in  ADDR_W  I-cache block address
- D_I  in  BLOCK_W  I-cache write block
- Rdy_I  out  1  I-cache transaction done (1-cycle pulse)
- Req_D, Wr_D, A_D, D_D, Rdy_D: same as the I-cache set, for the D-cache
- Req_Mem, Wr_Mem  out  1 each  request / write to memory
- A_Mem  out  ADDR_W  memory block address
- D_Mem  out  BLOCK_W  memory write block
- Rdy_Mem  in  1  memory transaction done
- Q_Mem  in  BLOCK_W  memory read block
- Q_Out  out  BLOCK_W  Q_Mem forwarded to both caches; consumers qualify it with their Rdy
- Err  out  1  sticky watchdog error

## Operation
- States are IDLE, GNT_I and GNT_D. The registered state is the grant; there is no separate grant register.
- **IDLE, one request:** grant that requester.
- **IDLE, both requesting:** grant the requester not marked by the last-served flag `last` (0 = I, 1 = D). `last` resets to 1, so I-cache wins the first tie.
- **IDLE, no request:** stay in IDLE.
- **GNT_x with Rdy_Mem=1:**
  - Pulse Rdy_x combinationally in the same cycle.
  - Set `last` to x.
  - Go to IDLE.
- **GNT_x with Rdy_Mem=0:** stay in GNT_x and increment the watchdog counter.
- **Watchdog expiry:** if the counter reaches TIMEOUT with Rdy_Mem still 0:
  - Set Err.
  - Go to IDLE.
  - Set `last` to x.
  - Do not pulse Rdy.
- **Counter:** clears on every IDLE cycle. It is 8 bits and does not wrap within a grant.
- **Memory-side muxing:** Req_Mem, Wr_Mem, A_Mem and D_Mem are a combinational mux selected by state. In IDLE they are all 0.
- **Requester drops Req mid-grant:** the grant is held anyway. The transaction completes on Rdy_Mem or on timeout.
- **Rdy_Mem outside a grant:** Rdy_Mem in IDLE is ignored. Neither Rdy pulses and no state changes.
- **Back-to-back transactions:** D-cache WB followed by MB is two independent transactions. The I-cache may be granted in between if it is requesting, because `last`=D at that point.
- **Err:** clears only on rst.

## Timing
- **Reset values:**
  - state=IDLE, `last`=1, counter=0, Err=0.
  - Req_Mem, Wr_Mem, Rdy_I, Rdy_D = 0.
  - A_Mem, D_Mem = 0.
- **Grant latency:** a request seen in IDLE in cycle 0 gives the grant state from edge 0→1. Req_Mem is high in cycle 1.
- **Completion:** Rdy_Mem in cycle N gives Rdy_x in cycle N (combinational). Req_Mem is low in cycle N+1 (IDLE). The earliest next grant drives Req_Mem in cycle N+2.
- **Minimum spacing:** one IDLE cycle between consecutive transactions, including consecutive transactions from the same requester.
- **Timeout:** a grant entered at edge 0 with Rdy_Mem never high sets Err at the edge ending cycle TIMEOUT. It is in IDLE in cycle TIMEOUT+1.
- **Reset mid-grant:** the next cycle is IDLE with outputs at reset values. The in-flight transaction is abandoned and no Rdy is pulsed.

## Structure
- Package mem_arb_pkg holds:
  - state encodings: IDLE=2'b00, GNT_I=2'b01, GNT_D=2'b10
  - ADDR_W and BLOCK_W defaults
  - the TIMEOUT counter width
- One sub-module, mem_arb_watchdog: 8-bit counter with clear, enable and an expire output. Everything else lives in mem_arbiter.

## Test plan
- Req_I only, A_I=28'h0000123, Rdy_Mem at cycle 4 → Req_Mem cycles 1–4, A_Mem=28'h0000123, Rdy_I pulse at cycle 4, Req_Mem=0 at cycle 5.
- Req_I and Req_D both raised after reset → I granted first. D is granted at cycle N+1 after I's Rdy, with Req_Mem high at N+2. The next tie goes to I.
- D-cache write then read: Wr_D=1, D_D=128'hDEADBEEF… → Wr_Mem=1 and D_Mem=D_D during the grant. After Rdy_D, Req_D stays high with Wr_D=0 → second grant with Wr_Mem=0 and Q_Out=Q_Mem on Rdy_D.
- TIMEOUT=4, Req_D held, Rdy_Mem never high → Err=1 after cycle 4, IDLE in cycle 5, no Rdy_D pulse, Err stays high until rst.
- Rdy_Mem pulsed in IDLE → no Rdy_I/Rdy_D and no state change. rst asserted during GNT_I → IDLE next cycle, Req_Mem=0, Err=0.
